// File: rtl/serial_operand_sender.sv
// Bit-serial operand driver and result collector for the serial adder.
// Accepts a W-bit operand pair over in_vld/in_rdy, streams it LSB-first
// as vld/a/b/last beats, collects the adder's sum bit on each valid beat
// and presents the reassembled result with a one-cycle res_vld strobe.
//
// Handshake: an operand pair transfers on a posedge where in_vld and in_rdy
// are both 1; in_rdy does not depend on in_vld. The serial side has no
// back-pressure from the adder: a beat transfers on every posedge with
// vld=1, and stall only suppresses beats (a, b, last are 0 when vld=0).
module serial_operand_sender #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         stall,
    output logic         vld,
    output logic         a,
    output logic         b,
    output logic         last,
    input  logic         sum,
    output logic         res_vld,
    output logic [W-1:0] res,
    output logic [1:0]   dbg_state
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   sa;
    logic [W-1:0]   sb;
    logic [CW-1:0]  cnt;
    logic           accept;
    logic           beat;
    logic [W-1:0]   res_shift;

    // Result shifts in from the MSB end so the LSB-first sum lands in place.
    generate
        if (W == 1) begin : g_res_w1
            assign res_shift = sum;
        end else begin : g_res_wn
            assign res_shift = {sum, res[W-1:1]};
        end
    endgenerate

    assign dbg_state = state;

    // State register; reset forces IDLE immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt = state;
        in_rdy    = 1'b0;
        vld       = 1'b0;
        a         = 1'b0;
        b         = 1'b0;
        last      = 1'b0;
        res_vld   = 1'b0;
        accept    = 1'b0;
        beat      = 1'b0;
        case (state)
            IDLE: begin
                // in_rdy is gated by rst so nothing is offered during reset.
                in_rdy = rst;
                accept = in_vld;
                if (in_vld) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                vld  = !stall;
                a    = sa[0] & vld;
                b    = sb[0] & vld;
                last = (cnt == CNT_LAST) & vld;
                beat = vld;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                res_vld   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand shifters, beat counter and result collector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sa  <= '0;
            sb  <= '0;
            cnt <= '0;
            res <= '0;
        end else if (accept) begin
            sa  <= in_a;
            sb  <= in_b;
            cnt <= '0;
            res <= '0;
        end else if (beat) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            cnt <= cnt + 1'b1;
            res <= res_shift;
        end
    end

endmodule

// File: tb/tb_serial_operand_sender.sv
// Bench for serial_operand_sender with a behavioural serial adder in
// loopback. Expected streams and results come from the operands directly
// (bit i of each operand, (a+b) mod 256, W+1+stalls latency).
module tb_serial_operand_sender;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_vld;
    logic         in_rdy;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         stall;
    logic         vld;
    logic         a;
    logic         b;
    logic         last;
    logic         sum;
    logic         res_vld;
    logic [W-1:0] res;
    logic [1:0]   dbg_state;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    serial_operand_sender #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
        .in_a(in_a), .in_b(in_b), .stall(stall), .vld(vld), .a(a), .b(b),
        .last(last), .sum(sum), .res_vld(res_vld), .res(res),
        .dbg_state(dbg_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural serial adder: carry kept across beats, cleared after last.
    logic carry;
    assign sum = a ^ b ^ carry;
    always @(posedge clk or negedge rst) begin
        if (!rst) carry <= 1'b0;
        else if (vld) carry <= last ? 1'b0 : ((a & b) | (carry & (a ^ b)));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Runs one operation; checks every beat, gap, result and latency.
    task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b,
                          input logic [31:0] mask, input logic [7:0] exp,
                          input bit keep, input bit busy, output int acc);
        int wait_cnt;
        int beats;
        int ns;
        bit got;
        wait_cnt = 0;
        @(negedge clk);
        in_a = op_a; in_b = op_b; in_vld = 1'b1; stall = 1'b0;
        #1;
        while (!in_rdy && wait_cnt < 50) begin
            @(negedge clk); #1; wait_cnt++;
        end
        if (wait_cnt >= 50) chk("in_rdy_timeout", in_rdy, 1);
        acc = cyc;
        @(posedge clk);
        ns    = $countones(mask);
        beats = 0;
        got   = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            stall = (k < 32) ? mask[k] : 1'b0;
            if (busy) begin
                in_a = 8'($urandom); in_b = 8'($urandom);
                in_vld = 1'($urandom_range(0, 1));
            end else if (!keep) begin
                in_vld = 1'b0;
            end
            #1;
            if (res_vld) begin
                chk("done_latency", k, W + ns);
                chk("beat_count", beats, W);
                chk("res", res, exp);
                chk("vld_in_done", vld, 0);
                chk("rdy_in_done", in_rdy, 0);
                got = 1;
            end else if (vld) begin
                if (beats < W) begin
                    chk("a_bit", a, op_a[beats]);
                    chk("b_bit", b, op_b[beats]);
                end
                chk("last", last, beats == W - 1);
                chk("rdy_in_shift", in_rdy, 0);
                beats++;
            end else begin
                chk("gap_is_stall", stall, 1);
                chk("gap_quiet", {a, b, last}, 0);
            end
        end
        if (!got) chk("res_vld_timeout", res_vld, 1);
        stall = 1'b0;
        if (!keep) begin
            @(negedge clk);
            in_vld = 1'b0;
            #1;
            chk("rdy_after", in_rdy, 1);
            chk("single_res_vld", res_vld, 0);
            chk("res_hold", res, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  op_a;
        logic [7:0]  op_b;
        logic [31:0] mask;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int acc1;
        int acc2;
        logic [7:0] ra;
        logic [7:0] rb;

        vecs[0] = '{8'h05, 8'h03, 32'h00, 8'h08};
        vecs[1] = '{8'hFF, 8'h01, 32'h00, 8'h00};
        vecs[2] = '{8'h5A, 8'h59, 32'h44, 8'hB3};
        vecs[3] = '{8'h00, 8'h00, 32'h01, 8'h00};
        vecs[4] = '{8'h80, 8'h80, 32'hFF, 8'h00};
        vecs[5] = '{8'hA5, 8'h5A, 32'h00, 8'hFF};

        // Reset state.
        rst = 1'b0; in_vld = 1'b1; in_a = 8'hFF; in_b = 8'hFF; stall = 1'b0;
        #2;
        chk("rst_in_rdy", in_rdy, 0);
        chk("rst_outs", {vld, a, b, last, res_vld}, 0);
        chk("rst_res", res, 0);
        in_vld = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rdy_after_rst", in_rdy, 1);

        // Directed table.
        foreach (vecs[i]) run_op(vecs[i].op_a, vecs[i].op_b, vecs[i].mask, vecs[i].exp, 0, 0, acc1);

        // Back-to-back with in_vld held high.
        run_op(8'h10, 8'h20, 32'h0, 8'h30, 1, 0, acc1);
        run_op(8'h7F, 8'h01, 32'h0, 8'h80, 0, 0, acc2);
        chk("b2b_spacing", acc2 - acc1, W + 2);

        // Busy ignore with a known pair.
        run_op(8'h3C, 8'hC4, 32'h0, 8'h00, 0, 1, acc1);

        // Randomized operations against the arithmetic model.
        for (int n = 0; n < 24; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(ra, rb, $urandom & $urandom & 32'hFF, 8'(ra + rb), 0, n[0], acc1);
        end

        // Reset in the middle of an operation.
        @(negedge clk);
        in_a = 8'hAA; in_b = 8'h55; in_vld = 1'b1; stall = 1'b0;
        #1;
        chk("rm_rdy", in_rdy, 1);
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_vld = 1'b0;
            #1;
            chk("rm_beat_vld", vld, 1);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rm_outs", {vld, a, b, last, res_vld}, 0);
        chk("rm_res", res, 0);
        chk("rm_in_rdy", in_rdy, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("rm_no_res_vld", res_vld, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rm_rdy_release", in_rdy, 1);
        chk("rm_vld_release", vld, 0);
        run_op(8'h01, 8'h02, 32'h0, 8'h03, 0, 0, acc1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
